// File: rtl/i2s_pkg.sv
// i2s_pkg: shared sample type and channel constants for the I2S sample path.
package i2s_pkg;
  localparam int DATA_SIZE = 16;
  localparam logic CH_LEFT = 1'b0;
  localparam logic CH_RIGHT = 1'b1;
  typedef struct packed {
    logic channel;
    logic [DATA_SIZE-1:0] data;
  } i2s_sample_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: generic first-word-fall-through FIFO with registered level.
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_level;
  assign level = r_level;
  assign full = r_level == FULL_LVL;
  assign empty = r_level == '0;
  // Gating the head on empty keeps stale or pre-reset entries from ever showing.
  assign rdata = empty ? '0 : r_mem[r_rd];
  always_ff @(posedge clk) if (push) r_mem[r_wr] <= wdata;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_level <= '0;
    end else begin
      if (push) r_wr <= r_wr + 1'b1;
      if (pop) r_rd <= r_rd + 1'b1;
      r_level <= (push && !pop) ? r_level + 1'b1 : (pop && !push) ? r_level - 1'b1 : r_level;
    end
  end
endmodule

// File: rtl/i2s_sample_fifo.sv
// i2s_sample_fifo: captures receiver words on ws edges, tags the channel,
// and buffers them for a valid/ready consumer with sticky overflow.
module i2s_sample_fifo #(
  parameter int DATA_SIZE = i2s_pkg::DATA_SIZE,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i2s_ws,
  input  logic [DATA_SIZE-1:0] audio_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_channel,
  output logic [AW:0]          level,
  output logic                 overflow,
  input  logic                 clr_overflow
);
  import i2s_pkg::*;
  logic r_ws_d, r_overflow;
  logic w_capture, w_pop, w_push, w_full, w_empty, w_drop;
  assign w_capture = i2s_ws != r_ws_d;
  assign w_pop = m_valid && m_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push = w_capture && (!w_full || w_pop);
  assign w_drop = w_capture && !w_push;
  assign m_valid = !w_empty;
  assign overflow = r_overflow;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ws_d <= CH_LEFT;
      r_overflow <= 1'b0;
    end else begin
      r_ws_d <= i2s_ws;
      r_overflow <= w_drop ? 1'b1 : clr_overflow ? 1'b0 : r_overflow;
    end
  end
  sync_fifo #(.WIDTH(DATA_SIZE + 1), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(w_push),
    .pop(w_pop),
    .wdata({r_ws_d, audio_data}),
    .rdata({m_channel, m_data}),
    .full(w_full),
    .empty(w_empty),
    .level(level)
  );
endmodule

// File: tb/tb_i2s_sample_fifo.sv
// tb_i2s_sample_fifo: directed checks of capture, ordering, overflow, backpressure and reset.
module tb_i2s_sample_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i2s_ws = 1'b0;
  logic [15:0] audio_data = '0;
  logic m_valid, m_ready = 1'b0, m_channel, overflow, clr_overflow = 1'b0;
  logic [15:0] m_data;
  logic [4:0] level;
  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] exp_d [20];
  logic exp_c [20];
  always #5 clk = ~clk;
  i2s_sample_fifo #(.DATA_SIZE(16), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .i2s_ws(i2s_ws), .audio_data(audio_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_channel(m_channel),
    .level(level), .overflow(overflow), .clr_overflow(clr_overflow)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic word(input logic [15:0] d);
    audio_data = d;
    i2s_ws = ~i2s_ws;
    tick();
  endtask
  task automatic fill(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      exp_d[i] = base + 16'(i);
      exp_c[i] = i2s_ws;
      word(exp_d[i]);
    end
  endtask
  task automatic drain();
    m_ready = 1'b1;
    for (int i = 0; i < 20 && m_valid; i++) tick();
    m_ready = 1'b0;
  endtask
  initial begin
    logic [15:0] t1 [3];
    logic [15:0] held;
    int n;
    t1[0] = 16'h1234; t1[1] = 16'hABCD; t1[2] = 16'h0F0F;
    tick(); tick();
    check("rst_valid", 32'(m_valid), 0);
    check("rst_data", 32'(m_data), 0);
    check("rst_chan", 32'(m_channel), 0);
    check("rst_level", 32'(level), 0);
    check("rst_ovf", 32'(overflow), 0);
    rst = 1'b1;
    m_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      word(t1[i]);
      check("t1_valid", 32'(m_valid), 1);
      check("t1_data", 32'(m_data), 32'(t1[i]));
      check("t1_chan", 32'(m_channel), 32'(i % 2));
      for (int k = 0; k < 16; k++) tick();
      check("t1_level", 32'(level), 0);
    end
    m_ready = 1'b0;
    fill(16, 16'h1000);
    check("t2_level16", 32'(level), 16);
    check("t2_ovf_pre", 32'(overflow), 0);
    word(16'h2000);
    check("t2_ovf", 32'(overflow), 1);
    check("t2_level_sat", 32'(level), 16);
    word(16'h2001); word(16'h2002); word(16'h2003);
    check("t2_level_end", 32'(level), 16);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t2_data", 32'(m_data), 32'(exp_d[i]));
      check("t2_chan", 32'(m_channel), 32'(exp_c[i]));
      tick();
    end
    check("t2_empty", 32'(m_valid), 0);
    m_ready = 1'b0;
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    check("t2_clr", 32'(overflow), 0);
    fill(16, 16'h3000);
    m_ready = 1'b1;
    word(16'hBEEF);
    m_ready = 1'b0;
    check("t3_level", 32'(level), 16);
    check("t3_ovf", 32'(overflow), 0);
    check("t3_head", 32'(m_data), 32'(exp_d[1]));
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("t3_last", 32'(m_data), 32'hBEEF);
      tick();
    end
    m_ready = 1'b0;
    check("t3_empty", 32'(level), 0);
    fill(2, 16'h4000);
    held = m_data;
    check("t4_head", 32'(held), 32'(exp_d[0]));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_data", 32'(m_data), 32'(exp_d[0]));
      check("t4_hold_chan", 32'(m_channel), 32'(exp_c[0]));
      check("t4_hold_lvl", 32'(level), 2);
    end
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    check("t4_pop_lvl", 32'(level), 1);
    check("t4_pop_data", 32'(m_data), 32'(exp_d[1]));
    drain();
    n = i2s_ws ? 6 : 5;
    fill(n, 16'h5000);
    check("t5_level", 32'(level), 32'(n));
    rst = 1'b0;
    word(16'hDEAD);
    rst = 1'b1;
    check("t5_valid", 32'(m_valid), 0);
    check("t5_level0", 32'(level), 0);
    check("t5_ovf", 32'(overflow), 0);
    tick(); tick();
    check("t5_still_empty", 32'(m_valid), 0);
    word(16'h5555);
    check("t5_new_data", 32'(m_data), 32'h5555);
    check("t5_new_chan", 32'(m_channel), 0);
    check("t5_new_lvl", 32'(level), 1);
    drain();
    fill(16, 16'h6000);
    clr_overflow = 1'b1;
    word(16'h7000);
    clr_overflow = 1'b0;
    check("t6_set_wins", 32'(overflow), 1);
    tick();
    check("t6_sticky", 32'(overflow), 1);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    check("t6_clr", 32'(overflow), 0);
    drain();
    check("t6_drained", 32'(level), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i2s_sample_fifo.md
Name: i2s_sample_fifo

Overview:
- Sits directly downstream of the I2S receiver.
- Detects each completed word by watching the receiver's i2s_ws output for edges. Captures the receiver's parallel audio_data word on that edge and tags it with its channel (L/R).
- Buffers tagged samples in a synchronous FIFO and presents them to the consumer (DSP, SPI/UART bridge) over a valid/ready stream.
- Flags overflow when the consumer falls behind.

Parameters:
DATA_SIZE, 16, sample width; must match the receiver (8, 16, 24 or 32).
DEPTH, 16, FIFO entries; power of two, >= 2.

Ports:
clk  in  1  system clock; same clock as the receiver.
rst  in  1  synchronous, active-low reset; sampled on posedge clk.
i2s_ws  in  1  word-select from the receiver; each toggle marks a completed word.
audio_data  in  DATA_SIZE  parallel word from the receiver; valid on the cycle the ws edge is seen.
m_valid  out  1  head sample available.
m_ready  in  1  consumer accepts the head sample.
m_data  out  DATA_SIZE  head sample data.
m_channel  out  1  head sample channel: 0 = left (word received while ws = 0), 1 = right.
level  out  $clog2(DEPTH)+1  number of stored entries.
overflow  out  1  sticky; set when a sample is dropped.
clr_overflow  in  1  clears overflow.

Behaviour:
- Reset (rst = 0 at posedge):
  - Outputs: m_valid = 0, m_data = 0, m_channel = 0, level = 0, overflow = 0.
  - Internal: read/write pointers = 0, ws_d = 0.
  - Reset mid-stream discards all stored samples; no partial entry survives.
- Edge detect:
  - ws_d <= i2s_ws every cycle.
  - capture = (i2s_ws != ws_d), a single-cycle strobe.
  - The receiver updates audio_data and toggles i2s_ws on the same edge, so audio_data is sampled in the capture cycle.
  - The channel tag is ws_d, i.e. the ws value during which the word was shifted.
  - The first edge after reset (ws 0->1) is captured as a left sample.
- Write:
  - When capture = 1 and the FIFO is not full: store {ws_d, audio_data} at wr_ptr and increment wr_ptr.
  - When capture = 1 and the FIFO is full: drop the sample, set overflow = 1, leave the pointers unchanged.
- Read:
  - Pop on m_valid && m_ready (rd_ptr increments).
  - m_data and m_channel show the head entry (first-word fall-through).
  - m_valid = (level != 0).
  - m_data and m_channel must be stable while m_valid = 1 && m_ready = 0.
- Latency: a sample captured at edge N is visible with m_valid = 1 after edge N+1 when the FIFO was empty (one cycle).
- Simultaneous push and pop:
  - Not full, not empty: both occur; level is unchanged.
  - Full: the pop frees a slot in the same cycle, so the push is accepted and there is no overflow.
  - Empty: only the push occurs; no pop, since m_valid = 0.
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH.
- level: the registered count, +1 on push only, -1 on pop only. Range 0..DEPTH.
  - full = (level == DEPTH).
  - empty = (level == 0).
- overflow:
  - Set has priority over clear when a drop and clr_overflow coincide.
  - Otherwise clr_overflow = 1 clears it on the next edge.
- Storage: may infer distributed RAM. The read path must stay combinational from the registered rd_ptr, so the output is FWFT with no extra bubble.
- No behaviour depends on the I2S bit rate; the receiver guarantees at least DATA_SIZE+1 cycles between ws edges.

Decomposition:
- Shared package i2s_pkg:
  - typedef i2s_sample_t = struct {logic channel; logic [DATA_SIZE-1:0] data;}, with DATA_SIZE as a package localparam defaulting to 16.
  - Constants CH_LEFT = 0 and CH_RIGHT = 1.
- One natural sub-module: sync_fifo, a generic FWFT FIFO with push/pop/full/empty/level and parameterised WIDTH and DEPTH.
- i2s_sample_fifo contains the ws edge detect, the channel tagging, the drop/overflow logic and one sync_fifo instance.

Test Plan:
1. Reset, then drive ws toggles every 17 cycles with audio_data = 0x1234, 0xABCD, 0x0F0F; hold m_ready = 1. Required: three outputs with m_channel = 0, 1, 0, data in order, each valid one cycle after the ws edge, and level returns to 0.
2. m_ready = 0 for 20 words (DEPTH = 16). Required: level saturates at 16, overflow = 1 after word 17, and words 1..16 are then read intact in order with words 17..20 absent.
3. FIFO full, then a ws edge in the same cycle as m_valid && m_ready. Required: the new sample is stored, level stays 16, and overflow stays 0.
4. Hold m_ready = 0 for 5 cycles with the FIFO non-empty. Required: m_data and m_channel are unchanged throughout, and the pop occurs only on the cycle m_ready = 1.
5. With 5 entries stored, assert rst = 0 for one cycle while a ws edge is pending. Required: the next cycle shows m_valid = 0, level = 0 and overflow = 0, and no sample from before the reset ever appears.
6. Drop coincident with clr_overflow = 1. Required: overflow remains 1. A later clr_overflow = 1 with no drop gives overflow = 0 on the next cycle.
